// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//   Pipelined immediate extender between instruction decode and the ID/EX
//   boundary. The IN_W-bit immediate is extended combinationally, then
//   carried through STAGES register stages together with its mode and a
//   valid bit. stall and flush move every stage in lockstep with the other
//   pipeline registers driven by the hazard unit.
//
//   Modes: 00 zero-extend, 01 sign-extend, 10 upper (immediate in the top
//   IN_W bits), 11 branch offset (sign-extend, then shift left by 2).
//
//   Handshake: an input is taken when in_valid=1 on a rising clk edge that
//   has neither stall nor flush; there is no ready, so an input presented
//   while stalled or flushed is lost and upstream must re-present it.
//   out_valid qualifies out_imm/out_mode for every cycle it is high.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   in_valid  in   in_imm is valid this cycle
//   in_imm    in   [IN_W-1:0] raw immediate field
//   mode      in   [1:0] extension mode
//   stall     in   hold every stage, drop the input
//   flush     in   invalidate and clear every stage (beats stall)
//   out_valid out  last-stage valid bit
//   out_imm   out  [OUT_W-1:0] last-stage extended immediate
//   out_mode  out  [1:0] mode that travelled with out_imm
//   busy      out  OR of all stage valid bits
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       mode,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_imm,
  output logic [1:0]       out_mode,
  output logic             busy
);

  localparam int PAD_W = OUT_W - IN_W;

  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_SIGN   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  logic             sign_bit;
  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] ext_d;

  // Stage 0 is the first register stage; stage STAGES-1 drives the outputs.
  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0][OUT_W-1:0] data_q;
  logic [STAGES-1:0][1:0]       mode_q;

  assign sign_bit = in_imm[IN_W-1];
  assign sign_ext = {{PAD_W{sign_bit}}, in_imm};

  always_comb begin
    ext_d = '0;
    case (mode)
      MODE_ZERO:   ext_d = {{PAD_W{1'b0}}, in_imm};
      MODE_SIGN:   ext_d = sign_ext;
      MODE_UPPER:  ext_d = {in_imm, {PAD_W{1'b0}}};
      // Bits shifted past the MSB are simply dropped.
      MODE_BRANCH: ext_d = sign_ext << 2;
      default:     ext_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      mode_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      data_q  <= '0;
      mode_q  <= '0;
    end else if (!stall) begin
      // Bubbles always carry zero data and mode.
      valid_q[0] <= in_valid;
      data_q[0]  <= in_valid ? ext_d : '0;
      mode_q[0]  <= in_valid ? mode  : 2'b00;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
        mode_q[i]  <= mode_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_imm   = data_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_extend_pipe
//   Directed bench for imm_extend_pipe. Four instances share one clock and
//   the control inputs:
//     a: IN_W=16 OUT_W=32 STAGES=2 (main configuration)
//     b: IN_W=16 OUT_W=32 STAGES=1
//     c: IN_W=16 OUT_W=32 STAGES=4
//     d: IN_W=12 OUT_W=20 STAGES=2 (own immediate input)
//   Inputs change 1 time unit after a rising edge; outputs are sampled
//   1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_imm_extend_pipe;

  localparam int A_IN_W = 16;
  localparam int A_OUT_W = 32;
  localparam int D_IN_W = 12;
  localparam int D_OUT_W = 20;

  if (A_OUT_W < A_IN_W + 2) begin : g_chk_a
    $error("OUT_W must be at least IN_W+2 (configuration a)");
  end
  if (D_OUT_W < D_IN_W + 2) begin : g_chk_d
    $error("OUT_W must be at least IN_W+2 (configuration d)");
  end

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              in_valid;
  logic [A_IN_W-1:0] in_imm;
  logic [D_IN_W-1:0] d_in_imm;
  logic [1:0]        mode;
  logic              stall;
  logic              flush;

  logic              a_valid, b_valid, c_valid, d_valid;
  logic [A_OUT_W-1:0] a_imm, b_imm, c_imm;
  logic [D_OUT_W-1:0] d_imm;
  logic [1:0]        a_mode, b_mode, c_mode, d_mode;
  logic              a_busy, b_busy, c_busy, d_busy;

  int tests_run = 0;
  int tests_failed = 0;

  imm_extend_pipe #(.IN_W(A_IN_W), .OUT_W(A_OUT_W), .STAGES(2)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_imm(in_imm), .mode(mode),
    .stall(stall), .flush(flush), .out_valid(a_valid), .out_imm(a_imm),
    .out_mode(a_mode), .busy(a_busy)
  );
  imm_extend_pipe #(.IN_W(A_IN_W), .OUT_W(A_OUT_W), .STAGES(1)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_imm(in_imm), .mode(mode),
    .stall(stall), .flush(flush), .out_valid(b_valid), .out_imm(b_imm),
    .out_mode(b_mode), .busy(b_busy)
  );
  imm_extend_pipe #(.IN_W(A_IN_W), .OUT_W(A_OUT_W), .STAGES(4)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_imm(in_imm), .mode(mode),
    .stall(stall), .flush(flush), .out_valid(c_valid), .out_imm(c_imm),
    .out_mode(c_mode), .busy(c_busy)
  );
  imm_extend_pipe #(.IN_W(D_IN_W), .OUT_W(D_OUT_W), .STAGES(2)) u_d (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_imm(d_in_imm), .mode(mode),
    .stall(stall), .flush(flush), .out_valid(d_valid), .out_imm(d_imm),
    .out_mode(d_mode), .busy(d_busy)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] m);
    in_valid = v;
    in_imm   = imm;
    mode     = m;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 16'h0000, 2'b00);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 16'h0000, 2'b00);
    d_in_imm = '0;
    stall = 1'b0;
    flush = 1'b0;
    step();
    step();
    tests_run++;
    if ({a_valid, a_imm, a_mode, a_busy} !== 36'd0) begin
      tests_failed++;
      $display("FAIL reset_a: got v=%b imm=%h mode=%b busy=%b, want all 0", a_valid, a_imm, a_mode, a_busy);
    end
    tests_run++;
    if ({c_valid, c_imm, c_busy} !== 34'd0) begin
      tests_failed++;
      $display("FAIL reset_c: got v=%b imm=%h busy=%b, want all 0", c_valid, c_imm, c_busy);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_sign_zero();
    drive(1'b1, 16'h8004, 2'b01);
    step();
    drive(1'b1, 16'h8004, 2'b00);
    tests_run++;
    if (a_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sign_early: out_valid=%b, want 0 after one edge", a_valid);
    end
    step();
    drive(1'b0, 16'h0000, 2'b00);
    tests_run++;
    if (a_valid !== 1'b1 || a_imm !== 32'hFFFF8004 || a_mode !== 2'b01) begin
      tests_failed++;
      $display("FAIL sign_ext: got v=%b imm=%h mode=%b, want 1 ffff8004 01", a_valid, a_imm, a_mode);
    end
    step();
    tests_run++;
    if (a_valid !== 1'b1 || a_imm !== 32'h00008004 || a_mode !== 2'b00) begin
      tests_failed++;
      $display("FAIL zero_ext: got v=%b imm=%h mode=%b, want 1 00008004 00", a_valid, a_imm, a_mode);
    end
    idle(5);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 16'h1234, 2'b10);
    step();
    drive(1'b1, 16'hFFFF, 2'b11);
    step();
    drive(1'b1, 16'h7FFF, 2'b11);
    tests_run++;
    if (a_valid !== 1'b1 || a_imm !== 32'h12340000 || a_mode !== 2'b10) begin
      tests_failed++;
      $display("FAIL upper: got v=%b imm=%h mode=%b, want 1 12340000 10", a_valid, a_imm, a_mode);
    end
    step();
    drive(1'b0, 16'h0000, 2'b00);
    tests_run++;
    if (a_valid !== 1'b1 || a_imm !== 32'hFFFFFFFC || a_mode !== 2'b11) begin
      tests_failed++;
      $display("FAIL branch_neg: got v=%b imm=%h mode=%b, want 1 fffffffc 11", a_valid, a_imm, a_mode);
    end
    step();
    tests_run++;
    if (a_valid !== 1'b1 || a_imm !== 32'h0001FFFC || a_mode !== 2'b11) begin
      tests_failed++;
      $display("FAIL branch_pos: got v=%b imm=%h mode=%b, want 1 0001fffc 11", a_valid, a_imm, a_mode);
    end
    step();
    tests_run++;
    if (a_valid !== 1'b0 || a_imm !== 32'h0 || a_mode !== 2'b00) begin
      tests_failed++;
      $display("FAIL bubble: got v=%b imm=%h mode=%b, want 0 00000000 00", a_valid, a_imm, a_mode);
    end
    idle(5);
  endtask

  task automatic test_stall();
    drive(1'b1, 16'h0001, 2'b01);
    step();
    stall = 1'b1;
    drive(1'b1, 16'h5555, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (a_valid !== 1'b0 || a_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got v=%b busy=%b, want 0 1", i, a_valid, a_busy);
      end
    end
    stall = 1'b0;
    drive(1'b0, 16'h0000, 2'b00);
    step();
    tests_run++;
    if (a_valid !== 1'b1 || a_imm !== 32'h00000001 || a_mode !== 2'b01) begin
      tests_failed++;
      $display("FAIL stall_release: got v=%b imm=%h mode=%b, want 1 00000001 01", a_valid, a_imm, a_mode);
    end
    step();
    tests_run++;
    if (a_valid !== 1'b0 || a_imm !== 32'h0 || a_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_drop: got v=%b imm=%h busy=%b, want 0 00000000 0", a_valid, a_imm, a_busy);
    end
    idle(5);
  endtask

  task automatic test_flush();
    drive(1'b1, 16'hAAAA, 2'b00);
    step();
    drive(1'b1, 16'hBBBB, 2'b01);
    step();
    tests_run++;
    if (a_valid !== 1'b1 || a_imm !== 32'h0000AAAA) begin
      tests_failed++;
      $display("FAIL flush_fill: got v=%b imm=%h, want 1 0000aaaa", a_valid, a_imm);
    end
    flush = 1'b1;
    stall = 1'b1;
    drive(1'b1, 16'hCCCC, 2'b10);
    step();
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 16'h0000, 2'b00);
    tests_run++;
    if (a_valid !== 1'b0 || a_imm !== 32'h0 || a_mode !== 2'b00 || a_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_stall: got v=%b imm=%h mode=%b busy=%b, want 0 0 00 0", a_valid, a_imm, a_mode, a_busy);
    end
    step();
    step();
    tests_run++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drop: got v=%b busy=%b, want 0 0", a_valid, a_busy);
    end
    idle(5);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'h1111, 2'b01);
    step();
    drive(1'b1, 16'h2222, 2'b01);
    step();
    drive(1'b0, 16'h0000, 2'b00);
    tests_run++;
    if (a_valid !== 1'b1 || a_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre: got v=%b busy=%b, want 1 1", a_valid, a_busy);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({a_valid, a_imm, a_mode, a_busy} !== 36'd0) begin
      tests_failed++;
      $display("FAIL areset_now: got v=%b imm=%h mode=%b busy=%b, want all 0", a_valid, a_imm, a_mode, a_busy);
    end
    #1 reset = 1'b0;
    drive(1'b1, 16'h00FF, 2'b01);
    step();
    drive(1'b0, 16'h0000, 2'b00);
    tests_run++;
    if (a_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_lat: out_valid=%b after one edge, want 0", a_valid);
    end
    step();
    tests_run++;
    if (a_valid !== 1'b1 || a_imm !== 32'h000000FF || a_mode !== 2'b01) begin
      tests_failed++;
      $display("FAIL areset_after: got v=%b imm=%h mode=%b, want 1 000000ff 01", a_valid, a_imm, a_mode);
    end
    idle(5);
  endtask

  task automatic test_param_sweep();
    drive(1'b1, 16'h8004, 2'b01);
    d_in_imm = 12'h800;
    step();
    drive(1'b0, 16'h0000, 2'b00);
    d_in_imm = '0;
    // edge 1: only STAGES=1 has produced its result
    tests_run++;
    if (b_valid !== 1'b1 || b_imm !== 32'hFFFF8004 || b_mode !== 2'b01) begin
      tests_failed++;
      $display("FAIL sweep_s1: got v=%b imm=%h mode=%b, want 1 ffff8004 01", b_valid, b_imm, b_mode);
    end
    tests_run++;
    if (d_valid !== 1'b0 || c_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep_e1: got d_v=%b c_v=%b, want 0 0", d_valid, c_valid);
    end
    step();
    tests_run++;
    if (d_valid !== 1'b1 || d_imm !== 20'hFF800 || d_mode !== 2'b01) begin
      tests_failed++;
      $display("FAIL sweep_w12: got v=%b imm=%h mode=%b, want 1 ff800 01", d_valid, d_imm, d_mode);
    end
    tests_run++;
    if (b_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep_s1_once: got v=%b, want 0", b_valid);
    end
    step();
    tests_run++;
    if (c_valid !== 1'b0 || c_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL sweep_s4_early: got v=%b busy=%b, want 0 1", c_valid, c_busy);
    end
    step();
    tests_run++;
    if (c_valid !== 1'b1 || c_imm !== 32'hFFFF8004 || c_mode !== 2'b01) begin
      tests_failed++;
      $display("FAIL sweep_s4: got v=%b imm=%h mode=%b, want 1 ffff8004 01", c_valid, c_imm, c_mode);
    end
    step();
    tests_run++;
    if (c_valid !== 1'b0 || c_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep_s4_drain: got v=%b busy=%b, want 0 0", c_valid, c_busy);
    end
    idle(2);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sign_zero();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
